// File: rtl/mem_arbiter_m1_pkg.sv
// Shared types for the LSU / instruction-fetch memory port arbiter.
package mem_arb_pkg_m1;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int DEST_W = 4;

    localparam logic [1:0] MODE_READ  = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;
    localparam logic [1:0] MODE_FENCE = 2'd2;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [1:0]        mask;
        logic [1:0]        fnc_type;
        logic [DATA_W-1:0] data;
        logic [1:0]        mode;
        logic [DEST_W-1:0] wb_dest;
    } mem_req_t;

    // Modes 2 and 3 are both fences; only the upper bit matters.
    function automatic logic is_fence(input logic [1:0] mode);
        return (mode & MODE_FENCE) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arbiter_m1_owner_fifo.sv
// In-order 1-bit owner FIFO for outstanding reads, with total and LSU-owned entry counts.
module owner_fifo_m1
    import mem_arb_pkg_m1::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             push,
    input  owner_t           push_owner,
    input  logic             pop,
    output owner_t           head,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] lsu_count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DEPTH-1:0] entries;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             lsu_inc;
    logic             lsu_dec;

    assign head    = owner_t'(entries[rd_ptr]);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign lsu_inc = push && (push_owner == OWN_LSU);
    assign lsu_dec = pop && (head == OWN_LSU);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lsu_count <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_owner;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({lsu_inc, lsu_dec})
                2'b10:   lsu_count <= lsu_count + 1'b1;
                2'b01:   lsu_count <= lsu_count - 1'b1;
                default: lsu_count <= lsu_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter_m1.sv
// Arbitrates LSU and fetch onto one memory port with read-owner tracking.
// Define MEM_ARB_LSU_PRIORITY_EN for fixed LSU priority instead of round-robin.
module mem_arbiter_m1
    import mem_arb_pkg_m1::*;
#(
    parameter int OUTST_DEPTH = 4,
    parameter int OUTST_W     = $clog2(OUTST_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        sync_rst,
    input  logic        lsu_req_en,
    input  logic [14:0] lsu_address,
    input  logic [1:0]  lsu_mask,
    input  logic [1:0]  lsu_fnc_type,
    input  logic [15:0] lsu_data,
    input  logic [1:0]  lsu_mode,
    input  logic [3:0]  lsu_wb_dest,
    output logic        lsu_grant,
    output logic [15:0] lsu_rdata,
    output logic [3:0]  lsu_rdest,
    output logic        lsu_ack,
    output logic        lsu_mem_idle,
    input  logic        if_req_en,
    input  logic [14:0] if_address,
    output logic        if_grant,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    output logic [14:0] mem_address_out,
    output logic [1:0]  mem_mask_out,
    output logic [1:0]  mem_read_fnc_type,
    output logic [15:0] mem_data_out,
    output logic [1:0]  mem_mode,
    output logic [3:0]  mem_wb_dest,
    output logic        mem_enable,
    input  logic        mem_available,
    input  logic        mem_idle,
    input  logic [15:0] mem_data_in,
    input  logic [3:0]  mem_wb_dest_in,
    input  logic        mem_read_ack,
    output logic        err_unexpected_ack
);

    mem_req_t           slot_p1;
    owner_t             slot_own_p1;
    mem_req_t           lsu_req;
    mem_req_t           if_req;
    logic               slot_free;
    logic               lsu_elig;
    logic               if_elig;
    logic               lsu_xfer;
    logic               if_xfer;
    logic               lsu_is_read;
    logic               fifo_push;
    logic               fifo_pop;
    owner_t             fifo_head;
    logic [OUTST_W-1:0] outst_cnt;
    logic [OUTST_W-1:0] lsu_outst;
    logic               fifo_full;
    logic               fifo_empty;

    assign lsu_req = '{address: lsu_address, mask: lsu_mask, fnc_type: lsu_fnc_type,
                       data: lsu_data, mode: lsu_mode, wb_dest: lsu_wb_dest};
    assign if_req  = '{address: if_address, mask: 2'b11, fnc_type: 2'b00,
                       data: '0, mode: MODE_READ, wb_dest: '0};

    // Slot can take a new request when empty or being drained this cycle.
    assign slot_free   = !mem_enable || mem_available;
    assign lsu_is_read = (lsu_mode == MODE_READ);

    always_comb begin
        lsu_elig = 1'b0;
        if (lsu_req_en && slot_free) begin
            if (is_fence(lsu_mode))
                lsu_elig = (outst_cnt == '0) && !mem_enable && mem_idle;
            else if (lsu_is_read)
                lsu_elig = !fifo_full;
            else
                lsu_elig = 1'b1;
        end
    end

    assign if_elig = if_req_en && slot_free && !fifo_full;

`ifdef MEM_ARB_LSU_PRIORITY_EN
    assign lsu_grant = lsu_elig;
`else
    owner_t last_grant;

    // On a tie the requester not granted last time wins.
    assign lsu_grant = lsu_elig && (!if_elig || last_grant == OWN_IF);

    always_ff @(posedge clk) begin
        if (sync_rst)
            last_grant <= OWN_IF;
        else if (lsu_xfer)
            last_grant <= OWN_LSU;
        else if (if_xfer)
            last_grant <= OWN_IF;
    end
`endif

    assign if_grant = if_elig && !lsu_grant;
    assign lsu_xfer = lsu_grant && clk_en;
    assign if_xfer  = if_grant && clk_en;

    assign fifo_push = (lsu_xfer && lsu_is_read) || if_xfer;
    assign fifo_pop  = clk_en && mem_read_ack && !fifo_empty;

    owner_fifo_m1 #(
        .DEPTH (OUTST_DEPTH),
        .CNT_W (OUTST_W)
    ) u_fifo (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .push       (fifo_push),
        .push_owner (lsu_xfer ? OWN_LSU : OWN_IF),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (outst_cnt),
        .lsu_count  (lsu_outst),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Stage p1: registered output slot toward the controller.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            mem_enable         <= 1'b0;
            slot_p1            <= '0;
            slot_own_p1        <= OWN_IF;
            err_unexpected_ack <= 1'b0;
        end else if (clk_en) begin
            if (slot_free) begin
                if (lsu_xfer) begin
                    slot_p1     <= lsu_req;
                    slot_own_p1 <= OWN_LSU;
                    mem_enable  <= 1'b1;
                end else if (if_xfer) begin
                    slot_p1     <= if_req;
                    slot_own_p1 <= OWN_IF;
                    mem_enable  <= 1'b1;
                end else begin
                    mem_enable  <= 1'b0;
                end
            end
            if (mem_read_ack && fifo_empty)
                err_unexpected_ack <= 1'b1;
        end
    end

    assign mem_address_out   = slot_p1.address;
    assign mem_mask_out      = slot_p1.mask;
    assign mem_read_fnc_type = slot_p1.fnc_type;
    assign mem_data_out      = slot_p1.data;
    assign mem_mode          = slot_p1.mode;
    assign mem_wb_dest       = slot_p1.wb_dest;

    assign lsu_rdata = mem_data_in;
    assign if_rdata  = mem_data_in;
    assign lsu_rdest = mem_wb_dest_in;
    assign lsu_ack   = mem_read_ack && !fifo_empty && (fifo_head == OWN_LSU);
    assign if_ack    = mem_read_ack && !fifo_empty && (fifo_head == OWN_IF);

    assign lsu_mem_idle = mem_idle && (lsu_outst == '0) &&
                          !(mem_enable && slot_own_p1 == OWN_LSU);

endmodule
